// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: opcodes plus the memory
// arbiter's state, owner and counter widths.
package risc_toy_pkg;

  localparam int MEM_LAT_W = 3;
  localparam int DSTREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20;
  localparam logic [4:0] OP_ST   = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

endpackage

// File: rtl/risc_arb_grant.sv
// Grant decision for the shared memory port, with the
// data-streak counter that bounds fetch starvation.
module risc_arb_grant
  import risc_toy_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_idle,
  input  logic i_ireq,
  input  logic i_iflush,
  input  logic i_dreq,
  output logic o_gnt_i,
  output logic o_gnt_d
);

  localparam logic [DSTREAK_W-1:0] LP_MAX =
    DSTREAK_W'(MAX_DSTREAK);

  logic [DSTREAK_W-1:0] r_dstreak;
  logic                 w_d_ok;

  always_comb begin
    w_d_ok  = !i_ireq || (r_dstreak < LP_MAX);
    o_gnt_d = i_idle && i_dreq && w_d_ok;
    o_gnt_i = i_idle && !o_gnt_d &&
              i_ireq && !i_iflush;
  end

  // streak only counts data grants that made a fetch wait
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dstreak <= '0;
    end else begin
      unique case (1'b1)
        o_gnt_i: r_dstreak <= '0;
        o_gnt_d: begin
          if (!i_ireq)
            r_dstreak <= '0;
          else if (r_dstreak < LP_MAX)
            r_dstreak <= r_dstreak + DSTREAK_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Arbitrates fetch and data ports of the RISC_TOY core onto
// one single-port synchronous SRAM with fixed latency.
module risc_mem_arbiter
  import risc_toy_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IREQ,
  input  logic [29:0]   IADDR,
  input  logic          IFLUSH,
  output logic [31:0]   INSTR,
  output logic          IACK,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  output logic          DACK,
  output logic          MREQ,
  output logic          MRW,
  output logic [AW-1:0] MADDR,
  output logic [31:0]   MWDATA,
  input  logic [31:0]   MRDATA
);

  localparam logic [MEM_LAT_W-1:0] LP_LAT =
    MEM_LAT_W'(MEM_LAT);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  arb_owner_e           r_owner;
  logic                 r_squash;
  logic [MEM_LAT_W-1:0] r_lat_cnt;
  logic [AW-1:0]        r_addr;
  logic                 r_rw;
  logic [31:0]          r_wdata;

  logic w_idle;
  logic w_last;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_unused;

  assign w_unused = ^{IADDR[29:AW], DADDR[29:AW]};
  assign w_idle   = (r_state == ST_IDLE);
  assign w_last   = (r_lat_cnt == MEM_LAT_W'(1));

  risc_arb_grant #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_grant (
    .i_clk    (CLK),
    .i_rst_n  (RSTN),
    .i_idle   (w_idle),
    .i_ireq   (IREQ),
    .i_iflush (IFLUSH),
    .i_dreq   (DREQ),
    .o_gnt_i  (w_gnt_i),
    .o_gnt_d  (w_gnt_d)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    MREQ        = 1'b0;
    MRW         = 1'b0;
    MADDR       = '0;
    MWDATA      = '0;
    IACK        = 1'b0;
    DACK        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_i || w_gnt_d)
          w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        MREQ        = 1'b1;
        MRW         = r_rw;
        MADDR       = r_addr;
        MWDATA      = r_wdata;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          // a flush arriving with the data still kills it
          IACK = (r_owner == OWN_I) &&
                 !r_squash && !IFLUSH;
          DACK = (r_owner == OWN_D);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    INSTR  = IACK ? MRDATA : '0;
    DRDATA = DACK ? MRDATA : '0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_owner   <= OWN_NONE;
      r_squash  <= 1'b0;
      r_lat_cnt <= '0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_wdata   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_squash <= 1'b0;
          if (w_gnt_d) begin
            r_owner <= OWN_D;
            r_addr  <= DADDR[AW-1:0];
            r_rw    <= DRW;
            r_wdata <= DWDATA;
          end else if (w_gnt_i) begin
            r_owner <= OWN_I;
            r_addr  <= IADDR[AW-1:0];
            r_rw    <= 1'b0;
            r_wdata <= '0;
          end
        end
        ST_ISSUE: begin
          r_lat_cnt <= LP_LAT;
          if (r_owner == OWN_I && IFLUSH)
            r_squash <= 1'b1;
        end
        ST_WAIT: begin
          r_lat_cnt <= r_lat_cnt - MEM_LAT_W'(1);
          if (r_owner == OWN_I && IFLUSH)
            r_squash <= 1'b1;
          if (w_last) begin
            r_owner  <= OWN_NONE;
            r_squash <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Directed bench: one arbiter at MEM_LAT=1 and one at
// MEM_LAT=3, sharing stimulus, each with its own SRAM model.
module tb_risc_mem_arbiter;

  logic        CLK;
  logic        RSTN;
  logic        IREQ;
  logic [29:0] IADDR;
  logic        IFLUSH;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;

  logic [31:0] instr1, drdata1, mwdata1, mrdata1;
  logic        iack1, dack1, mreq1, mrw1;
  logic [9:0]  maddr1;
  logic [31:0] instr3, drdata3, mwdata3, mrdata3;
  logic        iack3, dack3, mreq3, mrw3;
  logic [9:0]  maddr3;

  int n_run  = 0;
  int n_fail = 0;
  logic sel;

  risc_mem_arbiter #(
    .AW(10), .MEM_LAT(1), .MAX_DSTREAK(4)
  ) u_dut1 (
    .CLK(CLK), .RSTN(RSTN),
    .IREQ(IREQ), .IADDR(IADDR), .IFLUSH(IFLUSH),
    .INSTR(instr1), .IACK(iack1),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(drdata1), .DACK(dack1),
    .MREQ(mreq1), .MRW(mrw1), .MADDR(maddr1),
    .MWDATA(mwdata1), .MRDATA(mrdata1)
  );

  risc_mem_arbiter #(
    .AW(10), .MEM_LAT(3), .MAX_DSTREAK(4)
  ) u_dut3 (
    .CLK(CLK), .RSTN(RSTN),
    .IREQ(IREQ), .IADDR(IADDR), .IFLUSH(IFLUSH),
    .INSTR(instr3), .IACK(iack3),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(drdata3), .DACK(dack3),
    .MREQ(mreq3), .MRW(mrw3), .MADDR(maddr3),
    .MWDATA(mwdata3), .MRDATA(mrdata3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] minit(input logic [9:0] a);
    return (a == 10'h5) ? 32'hDEADBEEF
                        : (32'hCAFE0000 | 32'(a));
  endfunction

  bit [31:0]   mem1 [1024];
  bit          wv1  [1024];
  logic [31:0] p1;
  bit [31:0]   mem3 [1024];
  bit          wv3  [1024];
  logic [31:0] p3 [3];

  always @(posedge CLK) begin
    if (mreq1 && mrw1) begin
      mem1[maddr1] <= mwdata1;
      wv1[maddr1]  <= 1'b1;
    end
    p1 <= wv1[maddr1] ? mem1[maddr1] : minit(maddr1);
  end
  assign mrdata1 = p1;

  always @(posedge CLK) begin
    if (mreq3 && mrw3) begin
      mem3[maddr3] <= mwdata3;
      wv3[maddr3]  <= 1'b1;
    end
    p3[0] <= wv3[maddr3] ? mem3[maddr3] : minit(maddr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mrdata3 = p3[2];

  wire        iack_s  = sel ? iack3 : iack1;
  wire        dack_s  = sel ? dack3 : dack1;
  wire [31:0] instr_s = sel ? instr3 : instr1;
  wire [31:0] drd_s   = sel ? drdata3 : drdata1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  task automatic acc(input bit is_i, input bit rw,
                     input logic [29:0] a,
                     input logic [31:0] wd,
                     output logic [31:0] rd,
                     output int lat);
    bit done;
    done = 1'b0;
    lat  = 0;
    rd   = '0;
    if (is_i) begin
      IREQ  = 1'b1;
      IADDR = a;
    end else begin
      DREQ   = 1'b1;
      DRW    = rw;
      DADDR  = a;
      DWDATA = wd;
    end
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge CLK);
      if (is_i ? iack_s : dack_s) begin
        done = 1'b1;
        lat  = k;
        rd   = is_i ? instr_s : drd_s;
      end
    end
    IREQ = 1'b0;
    DREQ = 1'b0;
    chk("ack_seen", 32'(done), 32'd1);
  endtask

  logic [31:0] d;
  int          lat;
  logic [9:0]  seq;
  int          n;
  int          last;
  int          cnt;
  bit          ovl;

  initial begin
    RSTN = 1'b0; IREQ = 1'b0; IADDR = '0; IFLUSH = 1'b0;
    DREQ = 1'b0; DRW = 1'b0; DADDR = '0; DWDATA = '0;
    sel  = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst1_ctl", {28'd0, mreq1, mrw1, iack1, dack1}, 0);
    chk("rst1_bus", 32'(maddr1) | mwdata1 | instr1 | drdata1, 0);
    chk("rst3_ctl", {28'd0, mreq3, mrw3, iack3, dack3}, 0);
    chk("rst3_bus", 32'(maddr3) | mwdata3 | instr3 | drdata3, 0);
    RSTN = 1'b1;

    // single read, MEM_LAT=1
    @(negedge CLK);
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h5;
    @(negedge CLK);
    chk("rd_mreq", 32'(mreq1), 1);
    chk("rd_maddr", 32'(maddr1), 32'h5);
    chk("rd_mrw", 32'(mrw1), 0);
    chk("rd_dack_early", 32'(dack1), 0);
    chk("rd_drdata_idle", drdata1, 0);
    @(negedge CLK);
    chk("rd_dack", 32'(dack1), 1);
    chk("rd_data", drdata1, 32'hDEADBEEF);
    chk("rd_iack", 32'(iack1), 0);
    DREQ = 1'b0;
    @(negedge CLK);
    chk("rd_dack_pulse", 32'(dack1), 0);

    // write 0x3FF then read it back
    @(negedge CLK);
    DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h3FF;
    DWDATA = 32'h12345678;
    @(negedge CLK);
    chk("wr_mreq", 32'(mreq1), 1);
    chk("wr_mrw", 32'(mrw1), 1);
    chk("wr_maddr", 32'(maddr1), 32'h3FF);
    chk("wr_mwdata", mwdata1, 32'h12345678);
    @(negedge CLK);
    chk("wr_dack", 32'(dack1), 1);
    DREQ = 1'b0; DRW = 1'b0;
    @(negedge CLK);
    acc(1'b0, 1'b0, 30'h3FF, '0, d, lat);
    chk("wr_readback", d, 32'h12345678);
    chk("rd_lat1", 32'(lat), 2);

    // both ports held: D,D,D,D,I repeating
    @(negedge CLK);
    IREQ = 1'b1; IADDR = 30'h100;
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h200;
    seq = '0; n = 0; ovl = 1'b0;
    for (int k = 0; k < 80 && n < 10; k++) begin
      @(negedge CLK);
      if (iack1 && dack1) ovl = 1'b1;
      if (iack1 || dack1) begin
        seq[n] = iack1;
        n++;
      end
    end
    IREQ = 1'b0; DREQ = 1'b0;
    chk("streak_n", 32'(n), 10);
    chk("streak_seq", 32'(seq), 32'h210);
    chk("ack_overlap", 32'(ovl), 0);

    // switch to the MEM_LAT=3 instance from a clean reset
    @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    sel  = 1'b1;

    // fetch flushed in ISSUE
    @(negedge CLK);
    IREQ = 1'b1; IADDR = 30'h010;
    @(negedge CLK);
    chk("fl_mreq", 32'(mreq3), 1);
    chk("fl_maddr", 32'(maddr3), 32'h010);
    chk("fl_mrw", 32'(mrw3), 0);
    IFLUSH = 1'b1; IREQ = 1'b0;
    @(negedge CLK);
    IFLUSH = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (iack3) cnt++;
    end
    chk("fl_noack", 32'(cnt), 0);
    IREQ = 1'b1; IADDR = 30'h020; IFLUSH = 1'b1;
    @(negedge CLK);
    chk("fl_idle_nogrant", 32'(mreq3), 0);
    IFLUSH = 1'b0;
    acc(1'b1, 1'b0, 30'h020, '0, d, lat);
    chk("fl_next_instr", d, 32'hCAFE0020);
    chk("fl_next_lat", 32'(lat), 4);

    // flush landing in the IACK cycle
    @(negedge CLK);
    IREQ = 1'b1; IADDR = 30'h021;
    repeat (4) @(negedge CLK);
    IFLUSH = 1'b1; IREQ = 1'b0;
    #1;
    chk("fl_same_cycle", 32'(iack3), 0);
    @(negedge CLK);
    IFLUSH = 1'b0;
    repeat (2) @(negedge CLK);

    // back-to-back reads held on DREQ
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h30;
    n = 0; last = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge CLK);
      if (dack3) begin
        chk("b2b_data", drdata3, 32'hCAFE0030 + 32'(n));
        if (n > 0) chk("b2b_gap", 32'(k - last), 5);
        last = k;
        n++;
        DADDR = 30'h30 + 30'(n);
      end
    end
    DREQ = 1'b0;
    chk("b2b_n", 32'(n), 4);
    chk("b2b_dstreak", 32'(u_dut3.u_grant.r_dstreak), 0);
    repeat (2) @(negedge CLK);

    // reset in WAIT of a read
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h40;
    repeat (2) @(negedge CLK);
    RSTN = 1'b0;
    #1;
    chk("mr_ctl", {28'd0, mreq3, mrw3, iack3, dack3}, 0);
    chk("mr_bus", 32'(maddr3) | mwdata3 | drdata3, 0);
    DREQ = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (dack3) cnt++;
    end
    chk("mr_noack", 32'(cnt), 0);
    RSTN = 1'b1;
    @(negedge CLK);
    acc(1'b0, 1'b0, 30'h41, '0, d, lat);
    chk("mr_fresh_data", d, 32'hCAFE0041);
    chk("mr_fresh_lat", 32'(lat), 4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
